// File: rtl/lot_gate_controller.sv
// lot_gate_controller
//   Entry-gate controller and occupancy keeper for the parking lot. It takes
//   driver requests, reserves a space, opens the gate and commits the space
//   when the sensor FSM pulses inc. A reservation that is never used times out.
//   Occupancy is tracked from the inc/dec pulses, and the block flags full,
//   tailgate and underflow conditions.
//
//   Optional build macro LOT_STATS_EN adds two statistics outputs:
//     entries[15:0]  - wrapping count of every inc pulse, tailgates included
//     timeouts[7:0]  - saturating count of expired reservations
//
// Request handshake:
//   req is a level. It is sampled only in IDLE. Exactly one of grant or deny
//   pulses for one cycle, in the cycle after the sampling edge. A req held
//   while the lot is full is denied again on every cycle. A req raised in
//   OPEN or CLOSE is neither granted nor denied.
module lot_gate_controller #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int GATE_TIMEOUT = 16,
  parameter int CLOSE_HOLD   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             inc,
  input  logic             dec,
  output logic             gate_open,
  output logic             grant,
  output logic             deny,
  output logic             tailgate,
  output logic             timeout,
  output logic             full,
  output logic [CNT_W-1:0] count,
`ifdef LOT_STATS_EN
  output logic [15:0]      entries,
  output logic [7:0]       timeouts,
`endif
  output logic             err_uflow
);

  // One timer serves both the open window and the close hold.
  localparam int TMR_MAX = (GATE_TIMEOUT > CLOSE_HOLD) ? GATE_TIMEOUT : CLOSE_HOLD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAPACITY);
  localparam logic [CNT_W:0]   CAP_WIDE = (CNT_W + 1)'(CAPACITY);
  localparam logic [TMR_W-1:0] OPEN_END  = TMR_W'(GATE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] CLOSE_END = TMR_W'(CLOSE_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_CLOSE = 2'd2
  } state_t;

  state_t           state;
  logic             reserved;
  logic [TMR_W-1:0] timer;

  state_t           next_state;
  logic             next_reserved;
  logic [TMR_W-1:0] next_timer;
  logic [CNT_W-1:0] next_count;
  logic             next_gate;
  logic             next_grant;
  logic             next_deny;
  logic             next_timeout;
  logic             next_tailgate;
  logic             next_uflow;
  logic             next_full;

  // Gate sequencing: next state, reservation, timer and the gate/grant/deny/timeout pulses.
  always_comb begin
    next_state    = state;
    next_reserved = reserved;
    next_timer    = timer;
    next_gate     = 1'b0;
    next_grant    = 1'b0;
    next_deny     = 1'b0;
    next_timeout  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (!full) begin
            next_grant    = 1'b1;
            next_reserved = 1'b1;
            next_timer    = '0;
            next_state    = ST_OPEN;
            next_gate     = 1'b1;
          end else begin
            next_deny = 1'b1;
          end
        end
      end
      ST_OPEN: begin
        next_gate  = 1'b1;
        next_timer = timer + 1'b1;
        if (inc) begin
          next_reserved = 1'b0;
          next_state    = ST_CLOSE;
          next_timer    = '0;
          next_gate     = 1'b0;
        end else if (timer == OPEN_END) begin
          next_timeout  = 1'b1;
          next_reserved = 1'b0;
          next_state    = ST_CLOSE;
          next_timer    = '0;
          next_gate     = 1'b0;
        end
      end
      ST_CLOSE: begin
        if (timer == CLOSE_END) begin
          next_state = ST_IDLE;
          next_timer = '0;
        end else begin
          next_timer = timer + 1'b1;
        end
      end
      default: begin
        next_state    = ST_IDLE;
        next_reserved = 1'b0;
        next_timer    = '0;
      end
    endcase
  end

  // Occupancy update from the inc/dec pulses. Simultaneous inc and dec cancel out.
  always_comb begin
    next_count    = count;
    next_uflow    = err_uflow;
    next_tailgate = inc && (state != ST_OPEN);
    case ({inc, dec})
      2'b10: next_count = (count >= CAP_C) ? CAP_C : count + 1'b1;
      2'b01: begin
        if (count == '0) begin
          next_uflow = 1'b1;
        end else begin
          next_count = count - 1'b1;
        end
      end
      default: next_count = count;
    endcase
    // Computed from the post-update values so that full lines up with count.
    next_full = ({1'b0, next_count} + {{CNT_W{1'b0}}, next_reserved}) >= CAP_WIDE;
  end

  // Register the state and every output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      reserved  <= 1'b0;
      timer     <= '0;
      count     <= '0;
      gate_open <= 1'b0;
      grant     <= 1'b0;
      deny      <= 1'b0;
      tailgate  <= 1'b0;
      timeout   <= 1'b0;
      full      <= 1'b0;
      err_uflow <= 1'b0;
    end else begin
      state     <= next_state;
      reserved  <= next_reserved;
      timer     <= next_timer;
      count     <= next_count;
      gate_open <= next_gate;
      grant     <= next_grant;
      deny      <= next_deny;
      tailgate  <= next_tailgate;
      timeout   <= next_timeout;
      full      <= next_full;
      err_uflow <= next_uflow;
    end
  end

`ifdef LOT_STATS_EN
  // Statistics: entries wraps, and timeouts holds at its maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries  <= '0;
      timeouts <= '0;
    end else begin
      if (inc) begin
        entries <= entries + 16'd1;
      end
      if (next_timeout && (timeouts != 8'hFF)) begin
        timeouts <= timeouts + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lot_gate_controller.sv
// tb_lot_gate_controller
//   Directed test of lot_gate_controller with its default parameters
//   (CAPACITY 8, GATE_TIMEOUT 16, CLOSE_HOLD 4). Build with LOT_STATS_EN
//   defined to include the statistics outputs.
module tb_lot_gate_controller;

  logic       clk;
  logic       reset;
  logic       req;
  logic       inc;
  logic       dec;
  logic       gate_open;
  logic       grant;
  logic       deny;
  logic       tailgate;
  logic       timeout;
  logic       full;
  logic [3:0] count;
  logic       err_uflow;
`ifdef LOT_STATS_EN
  logic [15:0] entries;
  logic [7:0]  timeouts;
`endif

  int n_cmp;
  int n_err;

  lot_gate_controller dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .inc       (inc),
    .dec       (dec),
    .gate_open (gate_open),
    .grant     (grant),
    .deny      (deny),
    .tailgate  (tailgate),
    .timeout   (timeout),
    .full      (full),
    .count     (count),
`ifdef LOT_STATS_EN
    .entries   (entries),
    .timeouts  (timeouts),
`endif
    .err_uflow (err_uflow)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 1'b0;
    inc   = 1'b0;
    dec   = 1'b0;
    tick();
    check("rst_gate", gate_open, 1'b0);
    check("rst_grant", grant, 1'b0);
    check("rst_deny", deny, 1'b0);
    check("rst_tailgate", tailgate, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_uflow", err_uflow, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  // Driver: one complete normal entry, ending back in IDLE.
  task automatic do_entry();
    req = 1'b1;
    tick();
    req = 1'b0;
    check("entry_grant", grant, 1'b1);
    tick();
    inc = 1'b1;
    tick();
    inc = 1'b0;
    repeat (5) tick();
  endtask

  int  open_cycles;
  logic early_to;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    req   = 1'b0;
    inc   = 1'b0;
    dec   = 1'b0;

    // 1. Normal entry and close hold
    do_reset();
    req = 1'b1;
    tick();
    req = 1'b0;
    check("t1_grant", grant, 1'b1);
    check("t1_gate", gate_open, 1'b1);
    check("t1_full", full, 1'b0);
    tick();
    check("t1_grant_pulse", grant, 1'b0);
    check("t1_gate_held", gate_open, 1'b1);
    tick();
    inc = 1'b1;
    tick();
    inc = 1'b0;
    check("t1_count", count, 4'd1);
    check("t1_gate_closed", gate_open, 1'b0);
    check("t1_no_tailgate", tailgate, 1'b0);
    req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_hold_gate", gate_open, 1'b0);
      check("t1_hold_grant", grant, 1'b0);
      check("t1_hold_deny", deny, 1'b0);
    end
    tick();
    req = 1'b0;
    check("t1_regrant", grant, 1'b1);
    check("t1_regate", gate_open, 1'b1);

    // 2. Timeout: the reservation granted above is never used
    open_cycles = 1;
    early_to    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gate_open) begin
        open_cycles++;
        if (timeout) early_to = 1'b1;
      end else begin
        break;
      end
    end
    check("t2_gate_dropped", gate_open, 1'b0);
    check("t2_open_cycles", open_cycles, 16);
    check("t2_early_timeout", early_to, 1'b0);
    check("t2_timeout", timeout, 1'b1);
    check("t2_count", count, 4'd1);
    check("t2_full", full, 1'b0);
    tick();
    check("t2_timeout_pulse", timeout, 1'b0);
`ifdef LOT_STATS_EN
    check("t2_entries", entries, 16'd1);
    check("t2_timeouts", timeouts, 8'd1);
`endif
    repeat (5) tick();

    // 3. Full lot
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_entry();
    end
    check("t3_count8", count, 4'd8);
    check("t3_full", full, 1'b1);
    req = 1'b1;
    tick();
    check("t3_deny", deny, 1'b1);
    check("t3_no_grant", grant, 1'b0);
    check("t3_gate", gate_open, 1'b0);
    tick();
    check("t3_redeny", deny, 1'b1);
    req = 1'b0;
    tick();
    check("t3_deny_off", deny, 1'b0);
    inc = 1'b1;
    tick();
    inc = 1'b0;
    check("t3_tg_sat", tailgate, 1'b1);
    check("t3_count_sat", count, 4'd8);
    dec = 1'b1;
    tick();
    dec = 1'b0;
    check("t3_count7", count, 4'd7);
    check("t3_not_full", full, 1'b0);
    req = 1'b1;
    tick();
    req = 1'b0;
    check("t3_grant", grant, 1'b1);
    check("t3_full_resv", full, 1'b1);

    // 4. inc and dec together while OPEN, count 3
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_entry();
    end
    req = 1'b1;
    tick();
    req = 1'b0;
    check("t4_grant", grant, 1'b1);
    tick();
    inc = 1'b1;
    dec = 1'b1;
    tick();
    inc = 1'b0;
    dec = 1'b0;
    check("t4_count", count, 4'd3);
    check("t4_gate", gate_open, 1'b0);
    check("t4_tailgate", tailgate, 1'b0);
    check("t4_full", full, 1'b0);
    req = 1'b1;
    tick();
    req = 1'b0;
    check("t4_close_ignores_req", grant, 1'b0);

    // 5. Underflow and tailgate
    do_reset();
    dec = 1'b1;
    tick();
    dec = 1'b0;
    check("t5_count0", count, 4'd0);
    check("t5_uflow", err_uflow, 1'b1);
    tick();
    check("t5_uflow_sticky", err_uflow, 1'b1);
    inc = 1'b1;
    tick();
    inc = 1'b0;
    check("t5_tailgate", tailgate, 1'b1);
    check("t5_count1", count, 4'd1);
    tick();
    check("t5_tailgate_pulse", tailgate, 1'b0);
    check("t5_uflow_still", err_uflow, 1'b1);
    do_reset();

    // 6. Reset while OPEN
    do_entry();
    check("t6_count1", count, 4'd1);
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (4) tick();
    check("t6_open", gate_open, 1'b1);
`ifdef LOT_STATS_EN
    check("t6_entries", entries, 16'd1);
`endif
    reset = 1'b1;
    tick();
    check("t6_gate", gate_open, 1'b0);
    check("t6_count", count, 4'd0);
    check("t6_full", full, 1'b0);
`ifdef LOT_STATS_EN
    check("t6_entries_rst", entries, 16'd0);
`endif
    reset = 1'b0;
    req   = 1'b1;
    tick();
    req = 1'b0;
    check("t6_grant", grant, 1'b1);
    check("t6_gate_open", gate_open, 1'b1);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
